fp_addsub_param: RTL and testbench

FP_ADDSUB_PARAM -- requirements
Module: fp_addsub_param

---
 rtl/fp_addsub_param_if.sv | 20 ++
 rtl/fp_addsub_param.sv | 200 ++++++++++++++++++++
 tb/tb_fp_addsub_param.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_param_if.sv
// Request/result bundle for the multi-cycle floating-point adder/subtractor.
// The master drives the operands and start; the slave returns result, status and flags.
interface fp_addsub_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         valid;
    logic         busy;
    logic [3:0]   flags;

    modport master (output start, op, a, b, input result, valid, busy, flags);
    modport slave  (input start, op, a, b, output result, valid, busy, flags);
endinterface

// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE-754-style adder/subtractor: align, add, one-bit-per-cycle normalize,
// round to nearest even. Denormal inputs are flushed to signed zero.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic              clk,
    input logic              reset,
    fp_addsub_param_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 5;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_ONES = XW'((2 ** EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

    state_t               r_state, w_nextState;
    logic [W-1:0]         r_a, r_b, r_result;
    logic [3:0]           r_flags;
    logic [SW-1:0]        r_sig, r_addend;
    logic signed [XW-1:0] r_exp;
    logic                 r_sign, r_effSub, r_zero;

    logic [EXP_W-1:0] w_expA, w_expB, w_expBig, w_expSmall, w_expDiff;
    logic [MAN_W-1:0] w_fracA, w_fracB;
    logic             w_nanA, w_nanB, w_infA, w_infB, w_special, w_aBig, w_signBig;
    logic [W-2:0]     w_magA, w_magB, w_magBig, w_magSmall;
    logic [SW-1:0]    w_sigBig, w_sigSmall, w_shifted, w_lostMask, w_aligned;
    logic [31:0]      w_shamt;
    logic [W-1:0]     w_specialResult, w_roundResult;
    logic [3:0]       w_specialFlags, w_roundFlags;

    assign w_expA  = r_a[W-2:MAN_W];
    assign w_expB  = r_b[W-2:MAN_W];
    assign w_fracA = r_a[MAN_W-1:0];
    assign w_fracB = r_b[MAN_W-1:0];
    assign w_nanA  = (&w_expA) & (|w_fracA);
    assign w_nanB  = (&w_expB) & (|w_fracB);
    assign w_infA  = (&w_expA) & ~(|w_fracA);
    assign w_infB  = (&w_expB) & ~(|w_fracB);
    assign w_special = w_nanA | w_nanB | w_infA | w_infB;

    // Magnitude compare on {exp, frac} after flushing denormals picks the larger operand.
    assign w_magA     = (w_expA == '0) ? '0 : r_a[W-2:0];
    assign w_magB     = (w_expB == '0) ? '0 : r_b[W-2:0];
    assign w_aBig     = w_magA >= w_magB;
    assign w_magBig   = w_aBig ? w_magA : w_magB;
    assign w_magSmall = w_aBig ? w_magB : w_magA;
    assign w_signBig  = w_aBig ? r_a[W-1] : r_b[W-1];
    assign w_expBig   = w_magBig[W-2:MAN_W];
    assign w_expSmall = w_magSmall[W-2:MAN_W];
    assign w_expDiff  = w_expBig - w_expSmall;
    assign w_shamt    = (32'(w_expDiff) > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(w_expDiff);
    assign w_sigBig   = {1'b0, |w_expBig, w_magBig[MAN_W-1:0], 3'b000};
    assign w_sigSmall = {1'b0, |w_expSmall, w_magSmall[MAN_W-1:0], 3'b000};
    assign w_shifted  = w_sigSmall >> w_shamt;
    assign w_lostMask = ~({SW{1'b1}} << w_shamt);
    assign w_aligned  = {w_shifted[SW-1:1], w_shifted[0] | (|(w_sigSmall & w_lostMask))};

    always_comb begin
        w_specialResult = QNAN;
        w_specialFlags  = 4'b0000;
        if (!(w_nanA | w_nanB)) begin
            if (w_infA & w_infB & (r_a[W-1] != r_b[W-1]))
                w_specialFlags = 4'b1000;
            else if (w_infA)
                w_specialResult = r_a;
            else if (w_infB)
                w_specialResult = r_b;
        end
    end

    logic [SW-1:0] w_sum, w_sumNorm;
    logic          w_carry, w_sumZero;

    assign w_sum     = r_effSub ? (r_sig - r_addend) : (r_sig + r_addend);
    assign w_carry   = w_sum[SW-1];
    assign w_sumNorm = w_carry ? {1'b0, w_sum[SW-1:2], w_sum[1] | w_sum[0]} : w_sum;
    assign w_sumZero = (w_sum == '0);

    logic [MAN_W+1:0]     w_mant;
    logic [MAN_W-1:0]     w_fracR;
    logic                 w_roundUp, w_inexact;
    logic signed [XW-1:0] w_expR;

    // Round to nearest even on {G,R,S}; a mantissa carry renormalizes in the same cycle.
    assign w_inexact = |r_sig[2:0];
    assign w_roundUp = r_sig[2] & (r_sig[1] | r_sig[0] | r_sig[3]);
    assign w_mant    = {1'b0, r_sig[SW-2:3]} + {{(MAN_W+1){1'b0}}, w_roundUp};
    assign w_fracR   = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
    assign w_expR    = w_mant[MAN_W+1] ? r_exp + EXP_ONE : r_exp;

    always_comb begin
        w_roundResult = {r_sign, w_expR[EXP_W-1:0], w_fracR};
        w_roundFlags  = {3'b000, w_inexact};
        if (r_zero) begin
            w_roundResult = {r_sign, {(W-1){1'b0}}};
            w_roundFlags  = 4'b0000;
        end else if (w_expR >= EXP_ONES) begin
            w_roundResult = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_roundFlags  = 4'b0101;
        end else if (w_expR <= EXP_ZERO) begin
            w_roundResult = {r_sign, {(W-1){1'b0}}};
            w_roundFlags  = {3'b001, w_inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        bus.valid   = 1'b0;
        bus.busy    = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start)
                    w_nextState = S_ALIGN;
            end
            S_ALIGN: w_nextState = w_special ? S_DONE : S_ADD;
            S_ADD:   w_nextState = (w_sumZero | w_sumNorm[SW-2]) ? S_ROUND : S_NORM;
            S_NORM: begin
                if (r_sig[SW-3])
                    w_nextState = S_ROUND;
            end
            S_ROUND: w_nextState = S_DONE;
            S_DONE: begin
                bus.valid   = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // The op is folded into b's sign at capture so the rest of the datapath only adds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sig    <= '0;
            r_addend <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_effSub <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a <= bus.a;
                        r_b <= {bus.b[W-1] ^ bus.op, bus.b[W-2:0]};
                    end
                end
                S_ALIGN: begin
                    r_sig    <= w_sigBig;
                    r_addend <= w_aligned;
                    r_exp    <= {2'b00, w_expBig};
                    r_sign   <= w_signBig;
                    r_effSub <= r_a[W-1] ^ r_b[W-1];
                    r_zero   <= 1'b0;
                    if (w_special) begin
                        r_result <= w_specialResult;
                        r_flags  <= w_specialFlags;
                    end
                end
                S_ADD: begin
                    r_sig <= w_sumNorm;
                    r_exp <= w_carry ? r_exp + EXP_ONE : r_exp;
                    if (w_sumZero) begin
                        r_zero <= 1'b1;
                        r_sign <= r_a[W-1] & r_b[W-1];
                    end
                end
                S_NORM: begin
                    r_sig <= r_sig << 1;
                    r_exp <= r_exp - EXP_ONE;
                end
                S_ROUND: begin
                    r_result <= w_roundResult;
                    r_flags  <= w_roundFlags;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.flags  = r_flags;
endmodule

// File: tb/tb_fp_addsub_param.sv
// Self-checking bench for fp_addsub_param: directed corner cases, reset behaviour and
// randomized operands compared against an exact-arithmetic reference model.
module tb_fp_addsub_param;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fp_addsub_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    // Issues one operation and waits (bounded) for the valid pulse; edges counts the
    // start-sampling edge as 1 so the value equals the edge that entered DONE.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic op, input bit holdStart,
                                 output logic [31:0] result, output logic [3:0] flags,
                                 output int edges);
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        @(posedge clk);
        edges = 1;
        seen  = 1'b0;
        @(negedge clk);
        bus.start = holdStart;
        bus.a     = $urandom();
        bus.b     = $urandom();
        bus.op    = 1'($urandom());
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            seen = bus.valid;
        end
        bus.start = 1'b0;
        result    = bus.result;
        flags     = bus.flags;
        checkOutput({tag, "_completed"}, {31'd0, seen}, 32'd1);
        @(negedge clk);
        checkOutput({tag, "_validPulse"}, {31'd0, bus.valid}, 32'd0);
        checkOutput({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    // Exact reference: both operands scaled to a common integer grid, summed exactly,
    // then rounded to 24 significant bits with ties to even.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic op,
                                     output logic [31:0] res, output logic [3:0] fl);
        logic         sa, sb, sign, inexact;
        int           ea, eb, hi, lo, p, e, drop;
        logic [23:0]  ma, mb;
        logic [127:0] va, vb, mag, keep, rem, half;
        sa = a[31];
        sb = b[31] ^ op;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fl = 4'b0000;
        res = QNAN;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return;
        if (ea == 255 && eb == 255 && sa != sb) begin
            fl = 4'b1000;
            return;
        end
        if (ea == 255) begin res = {sa, a[30:0]}; return; end
        if (eb == 255) begin res = {sb, b[30:0]}; return; end
        ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
        hi = (ea > eb) ? ea : eb;
        lo = (ea > eb) ? eb : ea;
        if (hi - lo > 90) lo = hi - 90;
        va = (ea < lo) ? ((ma != 0) ? 128'd1 : 128'd0) : (128'(ma) << (ea - lo));
        vb = (eb < lo) ? ((mb != 0) ? 128'd1 : 128'd0) : (128'(mb) << (eb - lo));
        if (sa == sb) begin
            mag = va + vb; sign = sa;
        end else if (va >= vb) begin
            mag = va - vb; sign = sa;
        end else begin
            mag = vb - va; sign = sb;
        end
        if (mag == 0) begin
            res = {sa & sb, 31'd0};
            return;
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = p + lo - 23;
        inexact = 1'b0;
        if (p > 23) begin
            drop = p - 23;
            keep = mag >> drop;
            rem  = mag & ((128'd1 << drop) - 128'd1);
            half = 128'd1 << (drop - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
            if (keep[24]) begin keep = keep >> 1; e = e + 1; end
        end else begin
            keep = mag << (23 - p);
        end
        if (e >= 255) begin
            res = {sign, 8'hFF, 23'd0}; fl = 4'b0101;
        end else if (e <= 0) begin
            res = {sign, 31'd0}; fl = {3'b001, inexact};
        end else begin
            res = {sign, 8'(e), keep[22:0]}; fl = {3'b000, inexact};
        end
    endfunction

    function automatic logic [31:0] randOperand(input int nearExp);
        int          sel, e;
        logic        s;
        logic [22:0] f;
        sel = int'($urandom_range(0, 19));
        s   = 1'($urandom());
        f   = 23'($urandom());
        case (sel)
            0: return {s, 31'd0};
            1: return {s, 8'hFF, 23'd0};
            2: return {s, 8'hFF, f | 23'd1};
            3: return {s, 8'h00, f};
            4: return {s, 8'hFE, f};
            5: e = int'($urandom_range(1, 254));
            default: e = nearExp + int'($urandom_range(0, 8)) - 4;
        endcase
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {s, 8'(e), f};
    endfunction

    initial begin
        logic [31:0] res, ra, rb, expRes;
        logic [3:0]  fl, expFl;
        logic        rop, validSeen;
        int          edges;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_result", bus.result, 32'h0);
        checkOutput("reset_flags", {28'd0, bus.flags}, 32'h0);
        checkOutput("reset_valid", {31'd0, bus.valid}, 32'h0);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'h0);
        reset = 1'b0;

        applyStimulus("add_1_2", 32'h3F800000, 32'h40000000, 1'b0, 1'b0, res, fl, edges);
        checkOutput("add_1_2_result", res, 32'h40400000);
        checkOutput("add_1_2_flags", {28'd0, fl}, 32'h0);
        checkOutput("add_1_2_latency", edges, 32'd4);

        applyStimulus("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, res, fl, edges);
        checkOutput("inf_minus_inf_result", res, 32'h7FC00000);
        checkOutput("inf_minus_inf_flags", {28'd0, fl}, 32'h8);
        checkOutput("inf_minus_inf_latency", edges, 32'd2);

        applyStimulus("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 1'b0, res, fl, edges);
        checkOutput("tie_even_result", res, 32'h3F800000);
        checkOutput("tie_even_flags", {28'd0, fl}, 32'h1);

        applyStimulus("cancel", 32'h3F800000, 32'h3F7FFFFF, 1'b1, 1'b0, res, fl, edges);
        checkOutput("cancel_result", res, 32'h33800000);
        checkOutput("cancel_flags", {28'd0, fl}, 32'h0);
        checkOutput("cancel_latency", edges, 32'd28);

        applyStimulus("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, res, fl, edges);
        checkOutput("overflow_result", res, 32'h7F800000);
        checkOutput("overflow_flags", {28'd0, fl}, 32'h5);

        applyStimulus("neg_zeros", 32'h80000000, 32'h00000000, 1'b1, 1'b0, res, fl, edges);
        checkOutput("neg_zeros_result", res, 32'h80000000);

        // Start held high with changing operands must neither restart nor disturb the op.
        applyStimulus("hold_start", 32'h3F800000, 32'h40000000, 1'b0, 1'b1, res, fl, edges);
        checkOutput("hold_start_result", res, 32'h40400000);
        checkOutput("hold_start_latency", edges, 32'd4);

        // Abort the long cancellation case while it is normalizing.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F7FFFFF;
        bus.op    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'h0);
        checkOutput("abort_result", bus.result, 32'h0);
        checkOutput("abort_flags", {28'd0, bus.flags}, 32'h0);
        validSeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            validSeen = validSeen | bus.valid;
        end
        checkOutput("abort_no_valid", {31'd0, validSeen}, 32'h0);

        applyStimulus("after_abort", 32'h3F800000, 32'h40000000, 1'b0, 1'b0, res, fl, edges);
        checkOutput("after_abort_result", res, 32'h40400000);
        checkOutput("after_abort_latency", edges, 32'd4);

        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        checkOutput("reset_over_start_busy", {31'd0, bus.busy}, 32'h0);

        for (int i = 0; i < 300; i++) begin
            ra = randOperand(int'($urandom_range(1, 254)));
            if ($urandom_range(0, 4) == 0)
                rb = {1'($urandom()), ra[30:0] ^ 31'($urandom_range(0, 255))};
            else
                rb = randOperand(int'(ra[30:23]));
            rop = 1'($urandom());
            refModel(ra, rb, rop, expRes, expFl);
            applyStimulus($sformatf("rand%0d", i), ra, rb, rop, 1'b0, res, fl, edges);
            checkOutput($sformatf("rand%0d_result", i), res, expRes);
            checkOutput($sformatf("rand%0d_flags", i), {28'd0, fl}, {28'd0, expFl});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
